// File: rtl/antitheft_timer.sv
// antitheft_timer: reprogrammable countdown timer with 1 Hz tick generator for the alarm controller
module antitheft_timer #(
  parameter int         CLK_HZ     = 100_000_000,
  parameter logic [3:0] DEF_ARM    = 4'd6,
  parameter logic [3:0] DEF_DRIVER = 4'd8,
  parameter logic [3:0] DEF_PASS   = 4'd15,
  parameter logic [3:0] DEF_ALARM  = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       reprogram,
  input  logic       start_timer,
  input  logic [1:0] interval,
  output logic       one_hz_enable,
  output logic       expired,
  output logic       busy,
  output logic [3:0] count
);
  localparam int W = $clog2(CLK_HZ);
  localparam logic [W-1:0] DMAX = W'(CLK_HZ - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [3:0][3:0] param;
  logic [W-1:0] div;
  logic tick;
  assign tick = div == DMAX;
  // a load wins in every state; a tick only matters while running
  always_comb begin
    next = state;
    next = start_timer ? RUN :
           state == DONE ? IDLE :
           (state == RUN && tick && count == 4'd1) ? DONE : state;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      param         <= {DEF_ALARM, DEF_PASS, DEF_DRIVER, DEF_ARM};
      div           <= '0;
      one_hz_enable <= 1'b0;
      expired       <= 1'b0;
      busy          <= 1'b0;
      count         <= 4'd0;
    end else begin
      state         <= next;
      busy          <= next == RUN;
      expired       <= next == DONE;
      one_hz_enable <= tick;
      div           <= (start_timer || tick) ? '0 : div + 1'b1;
      count         <= start_timer ? param[interval] :
                       (state == RUN && tick) ? count - 4'd1 : count;
      if (reprogram) param[time_param_sel] <= (time_value == 4'd0) ? 4'd1 : time_value;
    end
  end
endmodule

// File: tb/tb_antitheft_timer.sv
// tb_antitheft_timer: directed and random checks of antitheft_timer against a time-based model
module tb_antitheft_timer;
  localparam int C = 4;
  logic clock = 1'b0, reset = 1'b0;
  logic [1:0] time_param_sel = '0, interval = '0;
  logic [3:0] time_value = '0;
  logic reprogram = 1'b0, start_timer = 1'b0;
  logic one_hz_enable, expired, busy;
  logic [3:0] count;
  int checks = 0, errors = 0;

  antitheft_timer #(.CLK_HZ(C)) dut (
    .clock(clock), .reset(reset), .time_param_sel(time_param_sel), .time_value(time_value),
    .reprogram(reprogram), .start_timer(start_timer), .interval(interval),
    .one_hz_enable(one_hz_enable), .expired(expired), .busy(busy), .count(count)
  );

  always #5 clock = ~clock;

  // model: outputs follow from elapsed edges since the last load and the tick phase origin
  int m_param [4] = '{6, 8, 15, 10};
  int cyc = 0, org = 0, ld_e = 0, ld_p = 0;
  bit loaded = 0;
  int e_cnt = 0;
  bit e_en = 0, e_exp = 0, e_busy = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_param = '{6, 8, 15, 10};
      loaded = 0; org = cyc;
      e_cnt = 0; e_en = 0; e_exp = 0; e_busy = 0;
    end else begin
      int d;
      cyc++;
      e_en = ((cyc - org) % C) == 0;
      if (start_timer) begin
        ld_e = cyc; ld_p = m_param[interval]; loaded = 1; org = cyc;
      end
      if (reprogram) m_param[time_param_sel] = (time_value == 0) ? 1 : int'(time_value);
      d = cyc - ld_e;
      e_busy = loaded && d < ld_p * C;
      e_exp  = loaded && d == ld_p * C;
      e_cnt  = (!loaded || d >= ld_p * C) ? 0 : ld_p - d / C;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      chk("count", int'(count), e_cnt);
      chk("busy", int'(busy), int'(e_busy));
      chk("expired", int'(expired), int'(e_exp));
      chk("one_hz_enable", int'(one_hz_enable), int'(e_en));
    end
  end

  task automatic pulse_start(input logic [1:0] iv);
    @(negedge clock); start_timer = 1'b1; interval = iv;
    @(negedge clock); start_timer = 1'b0;
  endtask

  task automatic write_param(input logic [1:0] sel, input logic [3:0] v);
    @(negedge clock); reprogram = 1'b1; time_param_sel = sel; time_value = v;
    @(negedge clock); reprogram = 1'b0;
  endtask

  task automatic cycles_to_expire(input string name, input int exp_n);
    int n = 0;
    while (!expired && n < 100) begin @(negedge clock); n++; end
    chk(name, n, exp_n);
  endtask

  task automatic wait_count(input int v);
    int n = 0;
    while (count != 4'(v) && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) chk("wait_count_timeout", int'(count), v);
  endtask

  initial begin
    int pulses, exp_seen;
    repeat (3) @(negedge clock);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_expired", int'(expired), 0);
    chk("rst_one_hz", int'(one_hz_enable), 0);
    #1 reset = 1'b1;
    pulse_start(2'd0); chk("def_arm", int'(count), 6);
    pulse_start(2'd1); chk("def_driver", int'(count), 8);
    pulse_start(2'd2); chk("def_pass", int'(count), 15);
    pulse_start(2'd3); chk("def_alarm", int'(count), 10);
    pulses = 0;
    repeat (16) begin @(negedge clock); pulses += int'(one_hz_enable); end
    chk("one_hz_pulses_16", pulses, 4);
    pulse_start(2'd1);
    chk("busy_after_load", int'(busy), 1);
    cycles_to_expire("driver_expire_cycles", 32);
    chk("done_busy", int'(busy), 0);
    chk("done_count", int'(count), 0);
    @(negedge clock); chk("expired_width", int'(expired), 0);
    write_param(2'd2, 4'd3);
    pulse_start(2'd2); chk("reprog_count", int'(count), 3);
    cycles_to_expire("reprog_expire_cycles", 12);
    write_param(2'd2, 4'd0);
    pulse_start(2'd2); chk("reprog_zero_min", int'(count), 1);
    cycles_to_expire("min_expire_cycles", 4);
    pulse_start(2'd3);
    wait_count(2);
    pulse_start(2'd3); chk("restart_count", int'(count), 10);
    cycles_to_expire("restart_expire_cycles", 40);
    @(negedge clock); start_timer = 1'b1; interval = 2'd3;
    repeat (5) @(negedge clock);
    start_timer = 1'b0;
    chk("hold_count", int'(count), 10);
    cycles_to_expire("hold_expire_cycles", 40);
    @(negedge clock); reprogram = 1'b1; time_param_sel = 2'd0; time_value = 4'd9;
    start_timer = 1'b1; interval = 2'd0;
    @(negedge clock); reprogram = 1'b0; start_timer = 1'b0;
    chk("collision_old", int'(count), 6);
    pulse_start(2'd0); chk("collision_new", int'(count), 9);
    wait_count(4);
    #1 reset = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_expired", int'(expired), 0);
    chk("async_one_hz", int'(one_hz_enable), 0);
    @(negedge clock); #1 reset = 1'b1;
    exp_seen = 0;
    repeat (60) begin @(negedge clock); exp_seen += int'(expired); end
    chk("no_expire_after_reset", exp_seen, 0);
    pulse_start(2'd0); chk("param_reverted", int'(count), 6);
    repeat (400) begin
      @(negedge clock);
      start_timer = ($urandom_range(0, 15) == 0);
      interval = 2'($urandom);
      reprogram = ($urandom_range(0, 7) == 0);
      time_param_sel = 2'($urandom);
      time_value = 4'($urandom_range(0, 5));
    end
    @(negedge clock); start_timer = 1'b0; reprogram = 1'b0;
    repeat (80) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/antitheft_timer.md
# antitheft_timer

Countdown timer stage for the anti-theft alarm controller. It holds four reprogrammable time parameters and generates the 1 Hz enable tick from the system clock. On `start_timer` it loads the parameter selected by `interval` and counts down in whole seconds, pulsing `expired` when the count reaches zero. It sits directly downstream of the alarm FSM: it consumes `start_timer`/`interval` and feeds `expired`/`one_hz_enable` back.

## Interface
- `CLK_HZ`, default 100_000_000: clock cycles per second. Must be ≥ 2.
- `DEF_ARM`, default 4'd6: reset value of the arming delay, slot 00.
- `DEF_DRIVER`, default 4'd8: reset value of the driver-door delay, slot 01.
- `DEF_PASS`, default 4'd15: reset value of the passenger-door delay, slot 10.
- `DEF_ALARM`, default 4'd10: reset value of the siren-on time, slot 11.

- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `time_param_sel` input 2: parameter slot to write.
- `time_value` input 4: new value in seconds.
- `reprogram` input 1: write strobe for the parameter slot, sampled each cycle.
- `start_timer` input 1: load and start; level-sensitive, sampled each cycle.
- `interval` input 2: parameter slot used by a load.
- `one_hz_enable` output 1: one-cycle tick, once per `CLK_HZ` cycles.
- `expired` output 1: one-cycle pulse when the countdown reaches 0.
- `busy` output 1: countdown in progress.
- `count` output 4: remaining seconds, for display.

## Operation
- Parameter file: four 4-bit registers.
  - When `reprogram`=1: `param[time_param_sel] <= (time_value==0) ? 1 : time_value`. The minimum stored value is 1 s.
  - A write never affects a countdown already running.
- Divider:
  - `div` has width `$clog2(CLK_HZ)`. It counts 0..`CLK_HZ-1` and wraps.
  - `one_hz_enable`=1 for exactly the cycle after `div`==`CLK_HZ-1`. The output is registered.
  - `div` is cleared whenever a load occurs, so the first second after start is a full `CLK_HZ` cycles.
- FSM states:
  - IDLE: `busy`=0. If `start_timer`=1, load `count <= param[interval]` and go to RUN.
  - RUN: `busy`=1.
    - If `start_timer`=1: reload `count` and clear `div`. A restart has priority over a tick.
    - Else, on a tick with `count`>1: decrement `count`.
    - Else, on a tick with `count`==1: set `count` to 0 and go to DONE.
  - DONE: `expired`=1 for this one cycle, `busy`=0, then go to IDLE. If `start_timer`=1 in DONE, load and go to RUN; `expired` is still asserted this cycle.
- `start_timer` held high for N cycles restarts the load on each of those cycles. Counting begins on the first cycle it is low.
- When `reprogram` and a load hit the same slot in the same cycle, the load uses the old value.
- `interval` is only sampled on load cycles.
- Reset: `count`=0, `expired`=0, `busy`=0, `one_hz_enable`=0, `div`=0, state IDLE, parameters = `DEF_*`. Asserting reset mid-countdown aborts it; `expired` is not generated.

## Timing
- All outputs are registered and change only on a rising `clock` or on asynchronous reset.
- Load latency: `start_timer` high at edge k gives `count`=param and `busy`=1 after edge k.
- Countdown: with the last load at edge k, `expired` is high during the cycle after edge k + P·`CLK_HZ`, where P is the loaded value.
- `expired` width is exactly 1 cycle.
- `one_hz_enable` runs continuously in every state, with period `CLK_HZ` cycles. It is re-phased by each load.
- `count` is 0 in DONE and holds its last value (0) in IDLE until the next load.
- An insertion of `reprogram` takes effect on the next edge and is visible to a load one cycle later.

## Test plan
- Reset defaults, `CLK_HZ`=4: release reset, load with `interval`=00, then 01, 10, 11 → `count` = 6, 8, 15, 10. `one_hz_enable` pulses every 4 cycles.
- Full countdown, `CLK_HZ`=4, `interval`=01: one-cycle `start_timer` → `count` goes 8..1, then `expired` pulses once 32 cycles after the load. `busy` is 1 throughout and 0 in the DONE cycle.
- Reprogram: `reprogram`=1, `time_param_sel`=10, `time_value`=3, then load slot 10 → `count`=3 and `expired` after 12 cycles. Writing `time_value`=0 gives a stored value of 1.
- Restart: reload slot 11 while `count`=2 → `count` returns to 10, `div` clears, and no `expired` occurs from the first run. Holding `start_timer` for 5 cycles delays counting until release.
- Same-cycle collision: write slot 00 to 9 and load slot 00 in the same cycle → loads 6. The next load gives 9.
- Async reset mid-run: pull `reset` low with `count`=4 and no clock edge → all outputs 0 immediately. Parameters revert to defaults and there is no `expired` after release.
